// File: rtl/rx_ingress_fifo_pkg.sv
// Shared dataplane definitions: write-side FSM states and the width of the
// packet/drop statistics counters exported to the CSR block.
package rx_ingress_fifo_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wr_state_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/rx_ingress_fifo.sv
// Store-and-forward ingress FIFO between the MAC and axi_rx.
// Beats are written tentatively at wr_ptr; a packet is only published to the
// egress side when its tlast beat lands, by moving cm_ptr up to wr_ptr.
// The MAC is never back-pressured: a packet that does not fit is rolled back
// to cm_ptr and the rest of it is discarded, counted once in drop_cnt.
module rx_ingress_fifo
  import rx_ingress_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic                      m_tvalid,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [DATA_WIDTH/8-1:0]   m_tkeep,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [CNT_W-1:0]          pkt_cnt,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = DATA_WIDTH / 8;
  localparam int EW = DATA_WIDTH + KW + 1;

  // Entry layout: {tdata, tkeep, tlast}
  logic [EW-1:0]    mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    cm_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    rd_ptr_d;
  logic [PW-1:0]    used_w;
  wr_state_e        state_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic             full;
  logic             wr_en;
  logic             rd_en;
  logic [EW-1:0]    rd_entry;

  // Occupancy counts tentative beats too, so an oversize packet always hits
  // full before its tlast and can never be committed.
  assign used_w   = wr_ptr_q - rd_ptr_q;
  assign full     = (used_w == PW'(DEPTH));
  assign wr_en    = s_tvalid && (state_q == ACCEPT) && !full;
  assign rd_en    = m_tvalid && m_tready;

  assign s_tready = ~rst;

  // Only committed beats are visible; first-word fall-through from rd_ptr.
  assign m_tvalid = (rd_ptr_q != cm_ptr_q);
  assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];
  assign m_tdata  = rd_entry[EW-1 -: DATA_WIDTH];
  assign m_tkeep  = rd_entry[KW:1];
  assign m_tlast  = rd_entry[0];

  assign level    = cm_ptr_q - rd_ptr_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

  assign rd_ptr_d = rd_en ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

  // Storage array: written on accepted beats only, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {s_tdata, s_tkeep, s_tlast};
    end
  end

  // Write FSM: accept/commit beats, or roll back and discard until tlast.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACCEPT;
      wr_ptr_q   <= '0;
      cm_ptr_q   <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else if (s_tvalid) begin
      case (state_q)
        ACCEPT: begin
          if (!full) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            if (s_tlast) begin
              cm_ptr_q  <= wr_ptr_q + PW'(1);
              pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            end
          end else begin
            wr_ptr_q   <= cm_ptr_q;
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            if (!s_tlast) begin
              state_q <= DROP;
            end
          end
        end
        DROP: begin
          if (s_tlast) begin
            state_q <= ACCEPT;
          end
        end
        default: state_q <= ACCEPT;
      endcase
    end
  end

  // Read pointer: advances on each egress handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_rx_ingress_fifo.sv
// Directed bench for rx_ingress_fifo: inputs driven 1ns after the rising
// edge, outputs checked at the same point (post-edge state).
module tb_rx_ingress_fifo;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_tvalid;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tlast;
  logic          s_tready;
  logic          m_tvalid;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tlast;
  logic          m_tready;
  logic [15:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
  logic [LW-1:0] level;

  int n_vec = 0;
  int n_err = 0;

  // Egress scoreboard for the random back-pressure run
  logic [DW+KW:0] exp_q[$];
  logic [DW+KW:0] exp_w;
  bit mon_en = 1'b0;
  int sent = 0;
  int rcvd = 0;

  rx_ingress_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .level    (level)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pd(int p, int b);
    return {16'hA5C3, 16'(p), 32'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Egress monitor: values stable at negedge are what the next edge consumes
  always @(negedge clk) begin
    if (mon_en && m_tvalid && m_tready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL egress_extra observed=%0h expected=none", m_tdata);
      end else begin
        exp_w = exp_q.pop_front();
        assert ({m_tdata, m_tkeep, m_tlast} === exp_w) else begin
          n_err++;
          $error("FAIL egress_beat observed=%0h expected=%0h", {m_tdata, m_tkeep, m_tlast}, exp_w);
        end
      end
      rcvd++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit any_vld;
    int plen;
    int guard;

    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b0;
    tick(); tick();
    // Reset state
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_level",    64'(level),    64'd0);
    rst = 1'b0;
    #1;
    chk("rel_s_tready", 64'(s_tready), 64'd1);

    // 3-beat packet, egress ready
    m_tready = 1'b1;
    beat(pd(1, 0), 8'hFF, 1'b0);
    chk("sf_b1_vld", 64'(m_tvalid), 64'd0);
    beat(pd(1, 1), 8'hFF, 1'b0);
    chk("sf_b2_vld", 64'(m_tvalid), 64'd0);
    beat(pd(1, 2), 8'h0F, 1'b1);
    chk("p1_vld",   64'(m_tvalid), 64'd1);
    chk("p1_d0",    m_tdata, pd(1, 0));
    chk("p1_level", 64'(level), 64'd3);
    chk("p1_pkt",   64'(pkt_cnt), 64'd1);
    tick();
    chk("p1_d1",    m_tdata, pd(1, 1));
    chk("p1_l1",    64'(m_tlast), 64'd0);
    tick();
    chk("p1_d2",    m_tdata, pd(1, 2));
    chk("p1_k2",    64'(m_tkeep), 64'h0F);
    chk("p1_l2",    64'(m_tlast), 64'd1);
    tick();
    chk("p1_empty", 64'(m_tvalid), 64'd0);
    chk("p1_lvl0",  64'(level), 64'd0);

    // Fill exactly to DEPTH, then a packet that cannot fit
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) beat(pd(2, i), 8'hFF, i == 15);
    chk("A_level", 64'(level), 64'd16);
    chk("A_pkt",   64'(pkt_cnt), 64'd2);
    beat(pd(3, 0), 8'hFF, 1'b0);
    beat(pd(3, 1), 8'hFF, 1'b1);
    chk("B_drop",  64'(drop_cnt), 64'd1);
    chk("B_level", 64'(level), 64'd16);
    chk("B_pkt",   64'(pkt_cnt), 64'd2);
    chk("A_hold",  m_tdata, pd(2, 0));
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("A_drain", m_tdata, pd(2, i));
      tick();
    end
    chk("A_empty", 64'(m_tvalid), 64'd0);

    // Oversize packet into an empty FIFO
    any_vld = 1'b0;
    for (int i = 0; i < 20; i++) begin
      beat(pd(4, i), 8'hFF, i == 19);
      any_vld |= m_tvalid;
    end
    chk("big_no_egress", 64'(any_vld), 64'd0);
    chk("big_drop",  64'(drop_cnt), 64'd2);
    chk("big_level", 64'(level), 64'd0);
    chk("big_pkt",   64'(pkt_cnt), 64'd2);
    beat(pd(5, 0), 8'h01, 1'b1);
    chk("C_vld",   64'(m_tvalid), 64'd1);
    chk("C_data",  m_tdata, pd(5, 0));
    chk("C_level", 64'(level), 64'd1);
    chk("C_pkt",   64'(pkt_cnt), 64'd3);
    tick();
    chk("C_empty", 64'(m_tvalid), 64'd0);

    // Full, with a read coinciding with an arriving 1-beat packet
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) beat(pd(6, i), 8'hFF, i == 15);
    chk("D_level", 64'(level), 64'd16);
    m_tready = 1'b1;
    beat(pd(7, 0), 8'hFF, 1'b1);
    m_tready = 1'b0;
    chk("E_drop",  64'(drop_cnt), 64'd3);
    chk("E_pkt",   64'(pkt_cnt), 64'd4);
    chk("E_level", 64'(level), 64'd15);
    chk("E_head",  m_tdata, pd(6, 1));
    m_tready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("D_drain", m_tdata, pd(6, i));
      tick();
    end
    chk("D_empty", 64'(m_tvalid), 64'd0);

    // Reset mid-packet
    beat(pd(8, 0), 8'hFF, 1'b0);
    beat(pd(8, 1), 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld",  64'(m_tvalid), 64'd0);
    chk("mid_rst_pkt",  64'(pkt_cnt),  64'd0);
    chk("mid_rst_drop", 64'(drop_cnt), 64'd0);
    chk("mid_rst_lvl",  64'(level),    64'd0);
    tick();
    rst = 1'b0;
    beat(pd(9, 0), 8'h03, 1'b1);
    chk("F_vld",  64'(m_tvalid), 64'd1);
    chk("F_data", m_tdata, pd(9, 0));
    chk("F_pkt",  64'(pkt_cnt), 64'd1);
    tick();
    chk("F_empty", 64'(m_tvalid), 64'd0);

    // 40 short packets under random back-pressure, checked by the monitor
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    for (int p = 0; p < 40; p++) begin
      guard = 0;
      m_tready = 1'b1;
      while ((sent - rcvd) > DEPTH - 3 && guard < 100) begin
        tick();
        guard++;
      end
      chk("pace_bound", 64'(guard < 100), 64'd1);
      plen = 1 + int'($urandom_range(0, 2));
      for (int b = 0; b < plen; b++) begin
        m_tready = 1'($urandom_range(0, 1));
        exp_q.push_back({pd(100 + p, b), 8'(8'h11 * (b + 1)), 1'(b == plen - 1)});
        sent++;
        beat(pd(100 + p, b), 8'(8'h11 * (b + 1)), b == plen - 1);
      end
    end
    m_tready = 1'b1;
    guard = 0;
    while (rcvd < sent && guard < 200) begin
      tick();
      guard++;
    end
    mon_en = 1'b0;
    chk("rand_rcvd",  64'(rcvd), 64'(sent));
    chk("rand_left",  64'(exp_q.size()), 64'd0);
    chk("rand_sum",   64'(pkt_cnt + drop_cnt), 64'd40);
    chk("rand_pkt",   64'(pkt_cnt), 64'd40);
    chk("rand_level", 64'(level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_ingress_fifo.md
RX_INGRESS_FIFO -- requirements
Module: rx_ingress_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: AXI-Stream tdata width in bits, a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 16: beat-entry capacity, a power of two, at least 4.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have ports s_tvalid/s_tdata/s_tkeep/s_tlast, inputs, widths 1/DATA_WIDTH/DATA_WIDTH/8/1: ingress stream from the MAC.
REQ-007 SHALL have port s_tready, output, 1 bit: ingress ready.
REQ-008 SHALL have ports m_tvalid/m_tdata/m_tkeep/m_tlast, outputs, widths 1/DATA_WIDTH/DATA_WIDTH/8/1: egress stream to axi_rx.
REQ-009 SHALL have port m_tready, input, 1 bit: egress ready from axi_rx.
REQ-010 SHALL have ports pkt_cnt and drop_cnt, outputs, 16 bits each: committed-packet and dropped-packet counts, read by the CSR block.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1 bits: committed beats currently held.

Function
REQ-012 SHALL operate store-and-forward: a packet becomes visible on the egress only after its tlast beat has been written.
REQ-013 SHALL keep three pointers of $clog2(DEPTH)+1 bits: wr_ptr (tentative), cm_ptr (commit) and rd_ptr; all wrap modulo 2*DEPTH.
REQ-014 SHALL define full as (wr_ptr - rd_ptr) == DEPTH, evaluated on registered pointers; there is no same-cycle read bypass.
REQ-015 SHALL hold s_tready at 1 whenever rst is low; the MAC is never back-pressured, and loss is handled by dropping.
REQ-016 SHALL run a write FSM with states ACCEPT and DROP.
REQ-017 In ACCEPT, when a beat arrives and the FIFO is not full, it SHALL store {tdata, tkeep, tlast} at wr_ptr and increment wr_ptr; if tlast=1, cm_ptr SHALL take wr_ptr+1 on the same edge and pkt_cnt SHALL increment.
REQ-018 In ACCEPT, when a beat arrives and the FIFO is full, it SHALL set wr_ptr to cm_ptr (rollback) and increment drop_cnt; it SHALL go to DROP if tlast=0 and stay in ACCEPT if tlast=1.
REQ-019 In DROP, it SHALL discard all beats, with no pointer change; a beat with tlast=1 SHALL return the FSM to ACCEPT.
REQ-020 SHALL drop a packet longer than DEPTH beats in every case, counting it once.
REQ-021 SHALL drive m_tvalid = (rd_ptr != cm_ptr) and m_tdata/m_tkeep/m_tlast combinationally from the entry at rd_ptr (first-word fall-through).
REQ-022 SHALL advance rd_ptr on m_tvalid && m_tready.
REQ-023 Latency: a tlast beat accepted at edge N SHALL give m_tvalid=1 at edge N+1 if the FIFO was previously empty.
REQ-024 SHALL keep m_tdata/m_tkeep/m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-025 SHALL drive level = cm_ptr - rd_ptr.
REQ-026 SHALL let pkt_cnt and drop_cnt wrap from 0xFFFF to 0.
REQ-027 On a simultaneous read and write, both SHALL take effect; full uses pre-edge pointers, so a write arriving while full is dropped even when a read occurs in the same cycle.

Reset
REQ-028 While rst=1, it SHALL set all pointers to 0, the FSM to ACCEPT, pkt_cnt=0, drop_cnt=0, level=0, m_tvalid=0 and s_tready=0.
REQ-029 Reset asserted mid-packet SHALL discard all stored and partial data; the first beat after release SHALL be treated as the start of a packet.
REQ-030 The storage array SHALL NOT require reset.

Structure
REQ-031 SHALL take the FSM state enum (ACCEPT, DROP) and the counter width constant from the shared dataplane package.
REQ-032 SHALL contain no sub-module; storage is an inferred register array.

Verification
REQ-033 Reset, then a 3-beat packet with tlast on beat 3 and m_tready=1 -> m_tvalid rises the cycle after beat 3, 3 beats egress in order, pkt_cnt=1.
REQ-034 m_tready=0, then 16-beat packet A, then a 2-beat packet B -> A stored with level=16; B dropped, drop_cnt=1; A then drains intact.
REQ-035 20-beat packet into an empty FIFO -> no egress, drop_cnt=1, level=0, wr_ptr==cm_ptr.
REQ-036 FIFO full, m_tready pulsed in the same cycle as an arriving single-beat packet -> that packet is dropped, one beat is read out.
REQ-037 rst asserted after 2 of 4 beats -> m_tvalid=0 and counters=0; the next 1-beat packet passes, pkt_cnt=1.
REQ-038 Random back-pressure on m_tready over 40 short packets -> egress beat order and content match ingress, and pkt_cnt+drop_cnt=40.
